// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared softmax constants, state encoding and power-term helper
package softmax_pkg;

    localparam int CH_NUM_DEF = 65;
    localparam int PWR_SHIFT  = 16;
    localparam int LOGIT_W    = 8;
    localparam int PWR_W      = 24;
    localparam int EXP_W      = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SUM  = 2'd1,
        ST_EXP  = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    // 2^(x-m+PWR_SHIFT), or 0 once the difference drops below -PWR_SHIFT
    function automatic logic [PWR_W-1:0] pwr_term(input logic [LOGIT_W-1:0] x,
                                                  input logic [LOGIT_W-1:0] m);
        logic signed [LOGIT_W:0] d;
        d = $signed({x[LOGIT_W-1], x}) - $signed({m[LOGIT_W-1], m});
        if (d < -PWR_SHIFT) begin
            return '0;
        end
        return PWR_W'(1) << (d + PWR_SHIFT);
    endfunction

endpackage

// File: rtl/lod24.sv
// rtl/lod24.sv - combinational 24-bit leading-one detector
module lod24 (
    input  logic [23:0] din,
    output logic [4:0]  pos
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < 24; i++) begin
            if (din[i]) begin
                pos = 5'(i);
            end
        end
    end

endmodule

// File: rtl/softmax_exp_accum.sv
// rtl/softmax_exp_accum.sv - per-cell max/power-sum accumulation and dividend replay
module softmax_exp_accum
    import softmax_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF
) (
    input  logic               aclk,
    input  logic               rst_n,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [LOGIT_W-1:0] s_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [EXP_W-1:0]   m_divisor_exponent,
    output logic [PWR_W-1:0]   m_dividend_power,
    output logic               m_tlast
);

    localparam int AW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CW = 8;
    localparam logic [CW-1:0] LAST = CW'(CH_NUM - 1);
    localparam logic [CW-1:0] NUM  = CW'(CH_NUM);

    state_t state, state_nxt;

    logic [LOGIT_W-1:0] buf_mem [0:CH_NUM-1];
    logic [LOGIT_W-1:0] rd_data;
    logic [LOGIT_W-1:0] max_q;
    logic [CW-1:0]      ch_cnt;
    logic [CW-1:0]      sum_cnt;
    logic [CW-1:0]      iss_cnt;
    logic [PWR_W-1:0]   s_q;
    logic [PWR_W:0]     s_sum;
    logic [PWR_W-1:0]   rd_term;
    logic [4:0]         lead_pos;
    logic [AW-1:0]      rd_addr;
    logic               pf_valid;
    logic               in_fire;
    logic               out_fire;
    logic               out_load;
    logic               iss;
    logic               rd_en;
    logic               acc_en;

    lod24 u_lod24 (
        .din (s_q),
        .pos (lead_pos)
    );

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (in_fire && ch_cnt == LAST)  state_nxt = ST_SUM;
            ST_SUM:  if (sum_cnt == NUM)             state_nxt = ST_EXP;
            ST_EXP:                                  state_nxt = ST_EMIT;
            ST_EMIT: if (out_fire && m_tlast)        state_nxt = ST_LOAD;
            default:                                 state_nxt = ST_LOAD;
        endcase
    end

    // EXP already fetches channel 0 so the first output beat is ready on EMIT entry
    always_comb begin
        s_tready = (state == ST_LOAD);
        in_fire  = s_tready && s_tvalid;
        out_fire = m_tvalid && m_tready;
        out_load = (state == ST_EMIT) && pf_valid && (!m_tvalid || m_tready);
        iss      = (state == ST_EXP) ||
                   ((state == ST_EMIT) && (iss_cnt < NUM) && (!pf_valid || out_load));
        rd_en    = ((state == ST_SUM) && (sum_cnt < NUM)) || iss;
        rd_addr  = (state == ST_SUM) ? sum_cnt[AW-1:0] : iss_cnt[AW-1:0];
        acc_en   = (state == ST_SUM) && (sum_cnt != '0);
    end

    assign rd_term = pwr_term(rd_data, max_q);
    assign s_sum   = {1'b0, s_q} + {1'b0, rd_term};

    always_ff @(posedge aclk) begin
        if (in_fire) begin
            buf_mem[ch_cnt[AW-1:0]] <= s_tdata;
        end
        if (rd_en) begin
            rd_data <= buf_mem[rd_addr];
        end
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            ch_cnt             <= '0;
            sum_cnt            <= '0;
            iss_cnt            <= '0;
            max_q              <= '0;
            s_q                <= '0;
            pf_valid           <= 1'b0;
            m_tvalid           <= 1'b0;
            m_tlast            <= 1'b0;
            m_dividend_power   <= '0;
            m_divisor_exponent <= '0;
        end else begin
            if (in_fire) begin
                ch_cnt <= (ch_cnt == LAST) ? '0 : ch_cnt + 1'b1;
                if (ch_cnt == '0 || $signed(s_tdata) > $signed(max_q)) begin
                    max_q <= s_tdata;
                end
            end

            sum_cnt <= (state == ST_SUM) ? sum_cnt + 1'b1 : '0;

            if (in_fire && ch_cnt == LAST) begin
                s_q <= '0;
            end else if (acc_en) begin
                s_q <= s_sum[PWR_W] ? '1 : s_sum[PWR_W-1:0];
            end

            if (state == ST_EXP) begin
                m_divisor_exponent <= EXP_W'(lead_pos) - EXP_W'(PWR_SHIFT);
            end

            if (iss) begin
                iss_cnt <= iss_cnt + 1'b1;
            end else if (state == ST_LOAD) begin
                iss_cnt <= '0;
            end

            if (iss) begin
                pf_valid <= 1'b1;
            end else if (out_load) begin
                pf_valid <= 1'b0;
            end

            if (out_load) begin
                m_tvalid         <= 1'b1;
                m_dividend_power <= rd_term;
                m_tlast          <= (iss_cnt == NUM);
            end else if (out_fire) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_softmax_exp_accum.sv
// tb/tb_softmax_exp_accum.sv - self-checking bench for softmax_exp_accum
module tb_softmax_exp_accum;

    localparam int CH = 65;

    logic        aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [7:0]  m_divisor_exponent;
    logic [23:0] m_dividend_power;
    logic        m_tlast;

    softmax_exp_accum #(.CH_NUM(CH)) dut (
        .aclk               (aclk),
        .rst_n              (rst_n),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .s_tdata            (s_tdata),
        .m_tvalid           (m_tvalid),
        .m_tready           (m_tready),
        .m_divisor_exponent (m_divisor_exponent),
        .m_dividend_power   (m_dividend_power),
        .m_tlast            (m_tlast)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int ready_pct;
        int e;
        int d0;
        int d1;
        int d2;
        int d5;
        int doth;
    } vec_t;

    vec_t vt[6];

    int total = 0;
    int bad = 0;
    int cur[CH];
    int ref_pow[CH];
    int ref_e;
    int got_pow[CH];
    int got_e[CH];
    int got_last[CH];
    int n_got;
    int stab_err;
    int block_err;
    int t_acc;
    int t_first;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference softmax front end: max, power terms, saturating sum, floor(log2)
    task automatic model();
        int mx;
        longint s;
        int p;
        mx = cur[0];
        for (int i = 1; i < CH; i++) if (cur[i] > mx) mx = cur[i];
        s = 0;
        for (int i = 0; i < CH; i++) begin
            int d;
            d = cur[i] - mx;
            ref_pow[i] = (d < -16) ? 0 : (1 << (d + 16));
            s += ref_pow[i];
        end
        if (s > 64'hFFFFFF) s = 64'hFFFFFF;
        p = 0;
        while ((64'd1 << (p + 1)) <= s) p++;
        ref_e = p - 16;
    endtask

    task automatic fill_kind(input int kind);
        for (int i = 0; i < CH; i++) begin
            case (kind)
                1:       cur[i] = -10;
                2, 3, 4: cur[i] = -128;
                default: cur[i] = 0;
            endcase
        end
        case (kind)
            1: cur[5] = 10;
            2: begin cur[0] = 0; cur[1] = -16; cur[2] = -17; end
            4: cur[0] = 127;
            5: cur[5] = 1;
            default: ;
        endcase
    endtask

    task automatic fill_random(input int mode);
        for (int i = 0; i < CH; i++) begin
            if (mode == 0) cur[i] = int'($urandom_range(0, 255)) - 128;
            else           cur[i] = int'($urandom_range(0, 24)) - 12;
        end
    endtask

    task automatic send_cell(input int bubble_pct);
        int i;
        int guard;
        bit fired;
        i = 0;
        guard = 0;
        while (i < CH && guard < 3000) begin
            if (int'($urandom_range(0, 99)) < bubble_pct) begin
                s_tvalid = 1'b0;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = 8'(cur[i]);
            end
            fired = s_tvalid && s_tready;
            @(posedge aclk); #1;
            guard++;
            if (fired) begin
                i++;
                if (i == CH) t_acc = cyc;
            end
        end
        s_tvalid = 1'b0;
        if (i != CH) check("send_timeout", i, CH);
    endtask

    task automatic collect(input int ready_pct, input int stall_at, input int stall_len,
                           input bit offer, input int rst_at);
        int n;
        int guard;
        int stall_left;
        bit stalled;
        bit hold;
        logic [23:0] hp;
        logic [7:0]  he;
        logic        hl;
        n = 0; guard = 0; stall_left = 0; stalled = 0; hold = 0;
        hp = '0; he = '0; hl = 1'b0;
        stab_err = 0; block_err = 0; t_first = -1;
        while (n < CH && guard < 4000) begin
            if (rst_at >= 0 && n == rst_at) begin
                rst_n = 1'b0;
                m_tready = 1'b0;
                @(posedge aclk); #1;
                rst_n = 1'b1;
                check("rst_mid_tvalid", m_tvalid, 0);
                check("rst_mid_tready", s_tready, 1);
                n_got = n;
                return;
            end
            if (m_tvalid && t_first < 0) t_first = cyc;
            if (hold && (!m_tvalid || m_dividend_power != hp ||
                         m_divisor_exponent != he || m_tlast != hl)) stab_err++;
            if (offer) begin
                s_tvalid = 1'b1;
                s_tdata  = 8'd55;
                if (s_tready) block_err++;
            end
            if (n == stall_at && !stalled) begin
                stall_left = stall_len;
                stalled = 1;
            end
            if (stall_left > 0) begin
                m_tready = 1'b0;
                stall_left--;
            end else begin
                m_tready = (int'($urandom_range(0, 99)) < ready_pct);
            end
            if (m_tvalid && m_tready) begin
                got_pow[n]  = int'(m_dividend_power);
                got_e[n]    = int'($signed(m_divisor_exponent));
                got_last[n] = int'(m_tlast);
                n++;
                hold = 0;
            end else begin
                hold = m_tvalid;
                hp = m_dividend_power;
                he = m_divisor_exponent;
                hl = m_tlast;
            end
            @(posedge aclk); #1;
            guard++;
        end
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        n_got = n;
    endtask

    task automatic check_cell(input string name);
        int dmis;
        int emis;
        int lmis;
        dmis = 0; emis = 0; lmis = 0;
        check({name, "_beats"}, n_got, CH);
        for (int i = 0; i < n_got; i++) begin
            if (got_pow[i] != ref_pow[i]) begin
                if (dmis == 0) $display("  %s ch%0d power %0d want %0d", name, i, got_pow[i], ref_pow[i]);
                dmis++;
            end
            if (got_e[i] != ref_e) emis++;
            if (got_last[i] != int'(i == CH - 1)) lmis++;
        end
        check({name, "_power_errs"}, dmis, 0);
        check({name, "_exp0"}, got_e[0], ref_e);
        check({name, "_exp_errs"}, emis, 0);
        check({name, "_tlast_errs"}, lmis, 0);
        check({name, "_stable_errs"}, stab_err, 0);
        check({name, "_blocked_errs"}, block_err, 0);
        check({name, "_idle_after"}, m_tvalid, 0);
    endtask

    initial begin
        vt[0] = '{kind: 0, ready_pct: 100, e: 6, d0: 65536, d1: 65536, d2: 65536, d5: 65536, doth: 65536};
        vt[1] = '{kind: 1, ready_pct: 100, e: 0, d0: 0,     d1: 0,     d2: 0,     d5: 65536, doth: 0};
        vt[2] = '{kind: 2, ready_pct: 100, e: 0, d0: 65536, d1: 1,     d2: 0,     d5: 0,     doth: 0};
        vt[3] = '{kind: 3, ready_pct: 70,  e: 6, d0: 65536, d1: 65536, d2: 65536, d5: 65536, doth: 65536};
        vt[4] = '{kind: 4, ready_pct: 50,  e: 0, d0: 65536, d1: 0,     d2: 0,     d5: 0,     doth: 0};
        vt[5] = '{kind: 5, ready_pct: 100, e: 5, d0: 32768, d1: 32768, d2: 32768, d5: 65536, doth: 32768};

        rst_n = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_s_tready", s_tready, 1);
        check("reset_m_tvalid", m_tvalid, 0);
        check("reset_m_tlast", m_tlast, 0);
        check("reset_power", m_dividend_power, 0);
        check("reset_exponent", m_divisor_exponent, 0);
        rst_n = 1'b1;
        @(posedge aclk); #1;

        for (int v = 0; v < 6; v++) begin
            fill_kind(vt[v].kind);
            for (int i = 0; i < CH; i++) ref_pow[i] = vt[v].doth;
            ref_pow[0] = vt[v].d0;
            ref_pow[1] = vt[v].d1;
            ref_pow[2] = vt[v].d2;
            ref_pow[5] = vt[v].d5;
            ref_e = vt[v].e;
            send_cell(0);
            collect(vt[v].ready_pct, -1, 0, 0, -1);
            check_cell($sformatf("vec%0d", v));
            if (v == 0) check("first_valid_latency", t_first - t_acc, CH + 3);
        end

        fill_kind(0);
        model();
        send_cell(0);
        collect(60, 32, 20, 0, -1);
        check_cell("backpressure");

        fill_random(1);
        model();
        send_cell(30);
        collect(100, -1, 0, 1, -1);
        check_cell("extra_offer");

        fill_random(1);
        cur[0] = 55;
        model();
        send_cell(30);
        collect(100, -1, 0, 0, -1);
        check_cell("after_extra");

        for (int r = 0; r < 6; r++) begin
            fill_random(r % 2);
            model();
            send_cell(20);
            collect(80, -1, 0, 0, -1);
            check_cell($sformatf("rand%0d", r));
        end

        fill_kind(0);
        model();
        send_cell(0);
        collect(100, -1, 0, 0, 30);

        fill_kind(0);
        model();
        send_cell(0);
        collect(100, -1, 0, 0, -1);
        check_cell("post_reset");
        check("post_reset_exp", got_e[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
